// File: rtl/adc_sample_ctrl.sv
// ADC conversion sequencer: CNV pulse, conversion wait, serial read over SCK/SDO,
// then one AXI4-Stream beat per conversion; triggers seen while busy are counted.
module adc_sample_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int CNV_CYCLES = 4,
  parameter int CONV_WAIT  = 88,
  parameter int SCK_DIV    = 2,
  parameter bit SIGN_EXT   = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trigger,
  output logic        adc_cnv,
  output logic        adc_sck,
  input  logic        adc_sdo,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic [15:0] overrun_count
);

  localparam int PERIOD  = 2 * SCK_DIV;
  localparam int CNT_MAX = (CNV_CYCLES > CONV_WAIT)
                         ? ((CNV_CYCLES > PERIOD) ? CNV_CYCLES : PERIOD)
                         : ((CONV_WAIT > PERIOD) ? CONV_WAIT : PERIOD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNV_LAST  = CNT_W'(CNV_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((CONV_WAIT > 0) ? CONV_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] SCK_HIGH  = CNT_W'(SCK_DIV);
  localparam logic [CNT_W-1:0] FALL_CNT  = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] PH_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_WAIT,
    S_READ,
    S_OUTPUT
  } state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [31:0]             sample_ext;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      m_axis_tdata  <= '0;
      overrun_count <= '0;
    end else begin
      state <= state_next;

      if (state != state_next || state == S_IDLE || state == S_OUTPUT)
        cnt <= '0;
      else if (state == S_READ && cnt == PH_LAST)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (state != S_READ)
        bit_cnt <= '0;
      else if (cnt == PH_LAST)
        bit_cnt <= bit_cnt + BIT_W'(1);

      // SDO is captured on the edge where SCK drops
      if (state == S_READ && cnt == FALL_CNT)
        shift_reg <= shift_next;

      if (state == S_READ && state_next == S_OUTPUT)
        m_axis_tdata <= sample_ext;

      if (trigger && state != S_IDLE && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (trigger) state_next = S_CONVERT;
      S_CONVERT: if (cnt == CNV_LAST) state_next = (CONV_WAIT == 0) ? S_READ : S_WAIT;
      S_WAIT:    if (cnt == WAIT_LAST) state_next = S_READ;
      S_READ:    if (cnt == PH_LAST && bit_cnt == BIT_LAST) state_next = S_OUTPUT;
      S_OUTPUT:  if (m_axis_tready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    shift_next    = shift_reg << 1;
    shift_next[0] = adc_sdo;
    if (SIGN_EXT)
      sample_ext = 32'($signed(shift_reg));
    else
      sample_ext = 32'(shift_reg);
  end

  always_comb begin
    adc_cnv       = (state == S_CONVERT);
    adc_sck       = (state == S_READ) && (cnt < SCK_HIGH);
    m_axis_tvalid = (state == S_OUTPUT);
    busy          = (state != S_IDLE);
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl: sign- and zero-extending instances share
// stimulus and a behavioural ADC that serves a programmed pattern MSB first.
module tb_adc_sample_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        trigger;
  logic        adc_sdo;
  logic        m_axis_tready;

  logic        adc_cnv_a, adc_sck_a, tvalid_a, busy_a;
  logic [31:0] tdata_a;
  logic [15:0] overrun_a;
  logic        adc_cnv_b, adc_sck_b, tvalid_b, busy_b;
  logic [31:0] tdata_b;
  logic [15:0] overrun_b;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [17:0] pattern;
  int          bit_idx = 0;
  int          sck_falls = 0;
  int          beats_a = 0;
  int          beats_b = 0;

  always #4 clk = ~clk;

  adc_sample_ctrl #(.SIGN_EXT(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .trigger(trigger),
    .adc_cnv(adc_cnv_a), .adc_sck(adc_sck_a), .adc_sdo(adc_sdo),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(m_axis_tready),
    .busy(busy_a), .overrun_count(overrun_a)
  );

  adc_sample_ctrl #(.SIGN_EXT(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .trigger(trigger),
    .adc_cnv(adc_cnv_b), .adc_sck(adc_sck_b), .adc_sdo(adc_sdo),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(m_axis_tready),
    .busy(busy_b), .overrun_count(overrun_b)
  );

  // ADC model: bit index restarts on CNV and advances after each SCK fall
  always @(posedge adc_cnv_a) bit_idx = 0;
  always @(negedge adc_sck_a) begin
    bit_idx   = bit_idx + 1;
    sck_falls = sck_falls + 1;
  end
  always_comb adc_sdo = (bit_idx < 18) ? pattern[17 - bit_idx] : 1'b0;

  always @(posedge clk) begin
    if (resetn && tvalid_a && m_axis_tready) beats_a <= beats_a + 1;
    if (resetn && tvalid_b && m_axis_tready) beats_b <= beats_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_tvalid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tvalid_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  logic        cnv_log   [0:170];
  logic        sck_log   [0:170];
  logic        valid_log [0:170];
  logic        busy_log  [0:170];
  logic [31:0] data_a_log, data_b_log;

  initial begin
    bit          ok;
    bit          stable;
    int          first_valid, first_sck, cnv_high, b0, valid_seen;
    logic [31:0] held_a, held_b;

    resetn        = 1'b0;
    trigger       = 1'b0;
    m_axis_tready = 1'b1;
    pattern       = 18'h2_A5A5;
    repeat (3) @(negedge clk);

    check("rst_cnv",     32'(adc_cnv_a), 32'd0);
    check("rst_sck",     32'(adc_sck_a), 32'd0);
    check("rst_tvalid",  32'(tvalid_a),  32'd0);
    check("rst_busy",    32'(busy_a),    32'd0);
    check("rst_tdata",   tdata_a,        32'd0);
    check("rst_overrun", 32'(overrun_a), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single conversion: index k holds values sampled by edge k+1
    sck_falls = 0;
    pulse_trigger();
    for (int k = 0; k <= 170; k++) begin
      cnv_log[k]   = adc_cnv_a;
      sck_log[k]   = adc_sck_a;
      valid_log[k] = tvalid_a;
      busy_log[k]  = busy_a;
      if (k == 164) begin
        data_a_log = tdata_a;
        data_b_log = tdata_b;
      end
      if (k < 170) @(negedge clk);
    end
    cnv_high    = 0;
    first_valid = -1;
    first_sck   = -1;
    for (int k = 0; k <= 170; k++) begin
      if (cnv_log[k]) cnv_high++;
      if (valid_log[k] && first_valid < 0) first_valid = k;
      if (sck_log[k] && first_sck < 0) first_sck = k;
    end
    check("cnv_first_edge",  32'(cnv_log[0]),  32'd1);
    check("cnv_last_edge",   32'(cnv_log[3]),  32'd1);
    check("cnv_drop",        32'(cnv_log[4]),  32'd0);
    check("cnv_cycles",      32'(cnv_high),    32'd4);
    check("sck_first_edge",  32'(first_sck),   32'd92);
    check("sck_falls",       32'(sck_falls),   32'd18);
    check("tvalid_edge",     32'(first_valid), 32'd164);
    check("tdata_signext",   data_a_log,       32'hFFFE_A5A5);
    check("tdata_zeroext",   data_b_log,       32'h0002_A5A5);
    check("busy_in_read",    32'(busy_log[100]), 32'd1);
    check("tvalid_after_hs", 32'(valid_log[165]), 32'd0);
    check("busy_after_hs",   32'(busy_log[165]),  32'd0);
    check("ovr_single_a",    32'(overrun_a), 32'd0);
    check("ovr_single_b",    32'(overrun_b), 32'd0);
    check("beats_single",    32'(beats_a),   32'd1);

    // Backpressure: tdata and tvalid held until tready
    pattern       = 18'h1_2345;
    m_axis_tready = 1'b0;
    b0 = beats_a;
    pulse_trigger();
    wait_tvalid(400, ok);
    check("bp_tvalid_seen", 32'(ok), 32'd1);
    held_a = tdata_a;
    held_b = tdata_b;
    check("bp_tdata_pos_a", held_a, 32'h0001_2345);
    check("bp_tdata_pos_b", held_b, 32'h0001_2345);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tvalid_a || !busy_a || tdata_a !== held_a || tdata_b !== held_b) stable = 1'b0;
    end
    check("bp_stable",   32'(stable),       32'd1);
    check("bp_no_beat",  32'(beats_a - b0), 32'd0);
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("bp_tvalid_drop", 32'(tvalid_a),     32'd0);
    check("bp_one_beat",    32'(beats_a - b0), 32'd1);
    repeat (5) @(negedge clk);
    check("bp_still_one",   32'(beats_a - b0), 32'd1);

    // Trigger every 10 cycles for 2000 cycles: 12 accepted, 188 dropped
    pattern = 18'h0_0001;
    b0 = beats_a;
    for (int c = 0; c < 2000; c++) begin
      trigger = (c % 10 == 0);
      @(negedge clk);
    end
    trigger = 1'b0;
    repeat (200) @(negedge clk);
    check("div10_samples_a", 32'(beats_a - b0), 32'd12);
    check("div10_samples_b", 32'(beats_b - b0), 32'd12);
    check("div10_overrun_a", 32'(overrun_a), 32'd188);
    check("div10_overrun_b", 32'(overrun_b), 32'd188);
    check("div10_tdata",     tdata_a,        32'h0000_0001);

    // Reset for one cycle in the middle of READ
    pattern = 18'h3_FFFF;
    b0 = beats_a;
    pulse_trigger();
    repeat (100) @(negedge clk);
    check("mid_read_busy", 32'(busy_a), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_sck",     32'(adc_sck_a), 32'd0);
    check("rst_mid_cnv",     32'(adc_cnv_a), 32'd0);
    check("rst_mid_busy",    32'(busy_a),    32'd0);
    check("rst_mid_tvalid",  32'(tvalid_a),  32'd0);
    check("rst_mid_overrun", 32'(overrun_a), 32'd0);
    resetn = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tvalid_a || tvalid_b) valid_seen++;
    end
    check("rst_no_tvalid", 32'(valid_seen),     32'd0);
    check("rst_no_beat",   32'(beats_a - b0),   32'd0);
    pulse_trigger();
    wait_tvalid(400, ok);
    check("post_rst_tvalid", 32'(ok),  32'd1);
    check("post_rst_data_a", tdata_a,  32'hFFFF_FFFF);
    check("post_rst_data_b", tdata_b,  32'h0003_FFFF);
    @(negedge clk);

    // Trigger held high long enough to exceed 65535 dropped events
    trigger = 1'b1;
    repeat (67000) @(negedge clk);
    check("ovr_saturate_a", 32'(overrun_a), 32'h0000_FFFF);
    check("ovr_saturate_b", 32'(overrun_b), 32'h0000_FFFF);
    repeat (20) @(negedge clk);
    check("ovr_hold", 32'(overrun_a), 32'h0000_FFFF);
    trigger = 1'b0;
    repeat (200) @(negedge clk);
    check("idle_at_end", 32'(busy_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
